// File: rtl/oflow_iou_pkg.sv
// rtl/oflow_iou_pkg.sv - widths, FSM states, bbox layout and coordinate helpers for the IoU engine
package oflow_iou_pkg;

    localparam int COORD_W  = 11;
    localparam int IOU_W    = 16;
    localparam int MAX_HIST = 8;
    localparam int IDX_W    = $clog2(MAX_HIST);
    localparam int CNT_W    = $clog2(MAX_HIST + 1);
    localparam int AREA_W   = 2 * COORD_W;
    localparam int UNION_W  = 2 * COORD_W + 1;
    localparam int BBOX_W   = 4 * COORD_W;

    localparam int X_TL_OFF = 3 * COORD_W;
    localparam int Y_TL_OFF = 2 * COORD_W;
    localparam int X_BR_OFF = 1 * COORD_W;
    localparam int Y_BR_OFF = 0;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_GEOM, S_DIV, S_OUT, S_DONE
    } state_t;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x_tl;
        coord_t y_tl;
        coord_t x_br;
        coord_t y_br;
    } bbox_t;

    function automatic bbox_t f_unpack(input logic [BBOX_W-1:0] v);
        bbox_t b;
        b.x_tl = v[X_TL_OFF +: COORD_W];
        b.y_tl = v[Y_TL_OFF +: COORD_W];
        b.x_br = v[X_BR_OFF +: COORD_W];
        b.y_br = v[Y_BR_OFF +: COORD_W];
        return b;
    endfunction

    function automatic coord_t f_min(input coord_t a, input coord_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_t f_max(input coord_t a, input coord_t b);
        return (a > b) ? a : b;
    endfunction

    // Inverted extents clamp to zero rather than wrapping.
    function automatic coord_t f_span(input coord_t lo, input coord_t hi);
        return (hi > lo) ? (hi - lo) : '0;
    endfunction

endpackage

// File: rtl/oflow_iou_serial_div.sv
// rtl/oflow_iou_serial_div.sv - restoring divider, one quotient bit per cycle, saturating quotient
module oflow_iou_serial_div #(
    parameter int DVD_W = 38,
    parameter int DVS_W = 23,
    parameter int Q_W   = 16
) (
    input  logic             clk,
    input  logic             reset_N,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quotient
);

    localparam int HI_W = DVD_W - Q_W;
    localparam int CW   = $clog2(Q_W);
    localparam logic [CW-1:0] LAST = CW'(Q_W - 1);

    logic [DVS_W-1:0] r_rem;
    logic [DVS_W-1:0] r_div;
    logic [Q_W-1:0]   r_low;
    logic [Q_W-1:0]   r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;

    logic [HI_W-1:0]  w_hi;
    logic [DVS_W:0]   w_shift;
    logic [DVS_W:0]   w_diff;
    logic             w_ge;

    assign w_hi    = i_dividend[DVD_W-1:Q_W];
    assign w_shift = {r_rem, r_low[Q_W-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_ge    = (w_shift >= {1'b0, r_div});

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_low  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_busy <= 1'b0;
            end else if (i_start && !r_busy) begin
                // A high part already >= divisor means the quotient cannot fit in Q_W bits.
                r_ovf  <= (DVS_W'(w_hi) >= i_divisor);
                r_rem  <= DVS_W'(w_hi);
                r_low  <= i_dividend[Q_W-1:0];
                r_div  <= i_divisor;
                r_q    <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_ge ? w_diff[DVS_W-1:0] : w_shift[DVS_W-1:0];
                r_q   <= {r_q[Q_W-2:0], w_ge};
                r_low <= {r_low[Q_W-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_ovf ? '1 : r_q;

endmodule

// File: rtl/oflow_iou_engine.sv
// rtl/oflow_iou_engine.sv - multi-candidate IoU cost engine; OFLOW_IOU_BEST_MATCH_EN adds best-match tracking
module oflow_iou_engine
    import oflow_iou_pkg::*;
(
    input  logic                clk,
    input  logic                reset_N,
    input  logic                start,
    input  logic                flush,
    input  logic [BBOX_W-1:0]   bbox_k,
    input  logic [CNT_W-1:0]    num_hist,
    input  logic                hist_valid,
    output logic                hist_ready,
    input  logic [BBOX_W-1:0]   hist_bbox,
    output logic                iou_valid,
    output logic [IOU_W-1:0]    iou_cost,
    output logic [IDX_W-1:0]    iou_idx,
    output logic                done,
    output logic [IDX_W-1:0]    best_idx,
    output logic [IOU_W-1:0]    best_cost
);

    localparam int DCW = $clog2(IOU_W);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(IOU_W - 1);

    state_t               r_state;
    bbox_t                r_k;
    bbox_t                r_h;
    logic [CNT_W-1:0]     r_num;
    logic [IDX_W-1:0]     r_idx;
    logic [AREA_W-1:0]    r_area_k;
    logic [DCW-1:0]       r_cnt;
    logic                 r_hist_ready;
    logic                 r_iou_valid;
    logic [IOU_W-1:0]     r_iou_cost;
    logic [IDX_W-1:0]     r_iou_idx;
    logic                 r_done;

    coord_t               w_wk, w_hk, w_wh, w_hh, w_ix, w_iy;
    logic [AREA_W-1:0]    w_area_k, w_area_h, w_inter;
    logic [UNION_W-1:0]   w_union;
    logic                 w_div_start, w_div_busy, w_div_done;
    logic [IOU_W-1:0]     w_quot, w_cost;
    logic                 w_last;

    assign w_wk     = f_span(r_k.x_tl, r_k.x_br);
    assign w_hk     = f_span(r_k.y_tl, r_k.y_br);
    assign w_wh     = f_span(r_h.x_tl, r_h.x_br);
    assign w_hh     = f_span(r_h.y_tl, r_h.y_br);
    assign w_ix     = f_span(f_max(r_k.x_tl, r_h.x_tl), f_min(r_k.x_br, r_h.x_br));
    assign w_iy     = f_span(f_max(r_k.y_tl, r_h.y_tl), f_min(r_k.y_br, r_h.y_br));
    assign w_area_k = AREA_W'(w_wk) * AREA_W'(w_hk);
    assign w_area_h = AREA_W'(w_wh) * AREA_W'(w_hh);
    assign w_inter  = AREA_W'(w_ix) * AREA_W'(w_iy);
    assign w_union  = UNION_W'(r_area_k) + UNION_W'(w_area_h) - UNION_W'(w_inter);

    // Empty union never starts the divider, so no done pulse arrives and the cost falls to all-ones.
    assign w_div_start = (r_state == S_GEOM) && !flush && (w_union != '0) && !w_div_busy;
    assign w_cost      = w_div_done ? ~w_quot : '1;
    assign w_last      = (CNT_W'(r_idx) + CNT_W'(1)) >= r_num;

    oflow_iou_serial_div #(
        .DVD_W (AREA_W + IOU_W),
        .DVS_W (UNION_W),
        .Q_W   (IOU_W)
    ) u_div (
        .clk        (clk),
        .reset_N    (reset_N),
        .i_start    (w_div_start),
        .i_abort    (flush),
        .i_dividend ({w_inter, {IOU_W{1'b0}}}),
        .i_divisor  (w_union),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_h          <= '0;
            r_num        <= '0;
            r_idx        <= '0;
            r_area_k     <= '0;
            r_cnt        <= '0;
            r_hist_ready <= 1'b0;
            r_iou_valid  <= 1'b0;
            r_iou_cost   <= '0;
            r_iou_idx    <= '0;
            r_done       <= 1'b0;
        end else begin
            r_iou_valid <= 1'b0;
            r_done      <= 1'b0;
            if (flush) begin
                r_state      <= S_IDLE;
                r_hist_ready <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_k     <= f_unpack(bbox_k);
                        r_num   <= num_hist;
                        r_state <= S_LOAD;
                    end
                    S_LOAD: begin
                        r_area_k <= w_area_k;
                        r_idx    <= '0;
                        if (r_num == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state      <= S_FETCH;
                            r_hist_ready <= 1'b1;
                        end
                    end
                    S_FETCH: if (hist_valid && r_hist_ready) begin
                        r_h          <= f_unpack(hist_bbox);
                        r_hist_ready <= 1'b0;
                        r_state      <= S_GEOM;
                    end
                    S_GEOM: begin
                        r_cnt   <= '0;
                        r_state <= S_DIV;
                    end
                    S_DIV: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == DIV_LAST) r_state <= S_OUT;
                    end
                    S_OUT: begin
                        r_iou_valid <= 1'b1;
                        r_iou_cost  <= w_cost;
                        r_iou_idx   <= r_idx;
                        r_idx       <= r_idx + 1'b1;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state      <= S_FETCH;
                            r_hist_ready <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef OFLOW_IOU_BEST_MATCH_EN
    logic [IDX_W-1:0] r_best_idx;
    logic [IOU_W-1:0] r_best_cost;

    // Strict compare keeps the earliest candidate on ties.
    always_ff @(posedge clk) begin
        if (!reset_N) begin
            r_best_idx  <= '0;
            r_best_cost <= '1;
        end else if (!flush) begin
            if (r_state == S_LOAD) begin
                r_best_idx  <= '0;
                r_best_cost <= '1;
            end else if ((r_state == S_OUT) && (w_cost < r_best_cost)) begin
                r_best_idx  <= r_idx;
                r_best_cost <= w_cost;
            end
        end
    end

    assign best_idx  = r_best_idx;
    assign best_cost = r_best_cost;
`else
    assign best_idx  = '0;
    assign best_cost = '1;
`endif

    assign hist_ready = r_hist_ready;
    assign iou_valid  = r_iou_valid;
    assign iou_cost   = r_iou_cost;
    assign iou_idx    = r_iou_idx;
    assign done       = r_done;

endmodule

// File: tb/tb_oflow_iou_engine.sv
// tb/tb_oflow_iou_engine.sv - directed self-checking bench for oflow_iou_engine
module tb_oflow_iou_engine;
    import oflow_iou_pkg::*;

    logic               clk = 1'b0;
    logic               reset_N = 1'b0;
    logic               start = 1'b0;
    logic               flush = 1'b0;
    logic [BBOX_W-1:0]  bbox_k = '0;
    logic [CNT_W-1:0]   num_hist = '0;
    logic               hist_valid = 1'b0;
    logic               hist_ready;
    logic [BBOX_W-1:0]  hist_bbox = '0;
    logic               iou_valid;
    logic [IOU_W-1:0]   iou_cost;
    logic [IDX_W-1:0]   iou_idx;
    logic               done;
    logic [IDX_W-1:0]   best_idx;
    logic [IOU_W-1:0]   best_cost;

    oflow_iou_engine dut (
        .clk        (clk),
        .reset_N    (reset_N),
        .start      (start),
        .flush      (flush),
        .bbox_k     (bbox_k),
        .num_hist   (num_hist),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_bbox  (hist_bbox),
        .iou_valid  (iou_valid),
        .iou_cost   (iou_cost),
        .iou_idx    (iou_idx),
        .done       (done),
        .best_idx   (best_idx),
        .best_cost  (best_cost)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rdy_cnt = 0;
    int start_cyc = 0;
    logic [IOU_W-1:0] q_cost[$];
    int q_idx[$];
    int q_lat[$];
    logic [BBOX_W-1:0] hb[MAX_HIST];
    int gp[MAX_HIST];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_N) begin
            if (hist_valid && hist_ready) acc_cyc <= cyc + 1;
            if (iou_valid) begin
                q_cost.push_back(iou_cost);
                q_idx.push_back(int'(iou_idx));
                q_lat.push_back(cyc - acc_cyc);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (hist_ready) rdy_cnt <= rdy_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BBOX_W-1:0] bb(input int xt, input int yt, input int xb, input int yb);
        logic [BBOX_W-1:0] v;
        v = '0;
        v[X_TL_OFF +: COORD_W] = COORD_W'(xt);
        v[Y_TL_OFF +: COORD_W] = COORD_W'(yt);
        v[X_BR_OFF +: COORD_W] = COORD_W'(xb);
        v[Y_BR_OFF +: COORD_W] = COORD_W'(yb);
        return v;
    endfunction

    task automatic clear_mon();
        @(negedge clk);
        q_cost.delete();
        q_idx.delete();
        q_lat.delete();
        done_cnt <= 0;
        rdy_cnt  <= 0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [BBOX_W-1:0] k, input int n);
        start     = 1'b1;
        bbox_k    = k;
        num_hist  = CNT_W'(n);
        start_cyc = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_hist(input logic [BBOX_W-1:0] b, input int gap);
        int n;
        repeat (gap) @(posedge clk);
        #1;
        hist_valid = 1'b1;
        hist_bbox  = b;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (hist_ready) break;
            n++;
            if (n > 300) begin
                check_eq("hist_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        hist_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check_eq("done_seen", 32'(done_cnt > 0), 32'd1);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [BBOX_W-1:0] k, input int n);
        clear_mon();
        pulse_start(k, n);
        for (int i = 0; i < n; i++) send_hist(hb[i], gp[i]);
        wait_done();
    endtask

    function automatic logic [31:0] cost_at(input int i);
        return (i < q_cost.size()) ? 32'(q_cost[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] idx_at(input int i);
        return (i < q_idx.size()) ? 32'(q_idx[i]) : 32'hDEAD_BEEF;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hist_ready", 32'(hist_ready), 32'd0);
        check_eq("rst_iou_valid", 32'(iou_valid), 32'd0);
        check_eq("rst_iou_cost", 32'(iou_cost), 32'd0);
        check_eq("rst_iou_idx", 32'(iou_idx), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_best_idx", 32'(best_idx), 32'd0);
        check_eq("rst_best_cost", 32'(best_cost), 32'hFFFF);
        @(posedge clk);
        #1;
        reset_N = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // identical boxes: full overlap, cost 0, fixed latency
        hb[0] = bb(10, 10, 20, 20); gp[0] = 0;
        run_job(bb(10, 10, 20, 20), 1);
        check_eq("t1_strobes", 32'(q_cost.size()), 32'd1);
        check_eq("t1_cost", cost_at(0), 32'h0000);
        check_eq("t1_idx", idx_at(0), 32'd0);
        check_eq("t1_latency", (q_lat.size() > 0) ? 32'(q_lat[0]) : 32'hDEAD, 32'd18);
        check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);

        // disjoint boxes
        hb[0] = bb(20, 20, 30, 30); gp[0] = 2;
        run_job(bb(0, 0, 10, 10), 1);
        check_eq("t2_strobes", 32'(q_cost.size()), 32'd1);
        check_eq("t2_cost", cost_at(0), 32'hFFFF);

        // inter 50, union 150
        hb[0] = bb(5, 0, 15, 10); gp[0] = 1;
        run_job(bb(0, 0, 10, 10), 1);
        check_eq("t3_strobes", 32'(q_cost.size()), 32'd1);
        check_eq("t3_cost", cost_at(0), 32'hAAAA);

        // three candidates with gapped valid
        hb[0] = bb(20, 20, 30, 30); gp[0] = 0;
        hb[1] = bb(5, 0, 15, 10);   gp[1] = 3;
        hb[2] = bb(0, 0, 10, 10);   gp[2] = 5;
        run_job(bb(0, 0, 10, 10), 3);
        check_eq("t4_strobes", 32'(q_cost.size()), 32'd3);
        check_eq("t4_cost0", cost_at(0), 32'hFFFF);
        check_eq("t4_cost1", cost_at(1), 32'hAAAA);
        check_eq("t4_cost2", cost_at(2), 32'h0000);
        check_eq("t4_idx0", idx_at(0), 32'd0);
        check_eq("t4_idx1", idx_at(1), 32'd1);
        check_eq("t4_idx2", idx_at(2), 32'd2);
        check_eq("t4_done_cnt", 32'(done_cnt), 32'd1);
`ifdef OFLOW_IOU_BEST_MATCH_EN
        check_eq("t4_best_idx", 32'(best_idx), 32'd2);
        check_eq("t4_best_cost", 32'(best_cost), 32'h0000);
`else
        check_eq("t4_best_idx", 32'(best_idx), 32'd0);
        check_eq("t4_best_cost", 32'(best_cost), 32'hFFFF);
`endif

        // inverted boxes collapse to zero area: empty union
        hb[0] = bb(10, 10, 5, 5); gp[0] = 0;
        run_job(bb(10, 10, 5, 5), 1);
        check_eq("t5_strobes", 32'(q_cost.size()), 32'd1);
        check_eq("t5_cost", cost_at(0), 32'hFFFF);

        // no candidates
        run_job(bb(0, 0, 10, 10), 0);
        check_eq("t6_done_latency", 32'(done_cyc - start_cyc), 32'd2);
        check_eq("t6_strobes", 32'(q_cost.size()), 32'd0);
        check_eq("t6_ready_cycles", 32'(rdy_cnt), 32'd0);
        check_eq("t6_done_cnt", 32'(done_cnt), 32'd1);

        // flush while dividing
        clear_mon();
        pulse_start(bb(0, 0, 10, 10), 1);
        send_hist(bb(5, 0, 15, 10), 0);
        repeat (7) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_eq("t7_flush_strobes", 32'(q_cost.size()), 32'd0);
        check_eq("t7_flush_done", 32'(done_cnt), 32'd0);
        check_eq("t7_flush_ready", 32'(hist_ready), 32'd0);
        @(posedge clk);
        #1;

        hb[0] = bb(5, 0, 15, 10); gp[0] = 0;
        run_job(bb(0, 0, 10, 10), 1);
        check_eq("t7_after_strobes", 32'(q_cost.size()), 32'd1);
        check_eq("t7_after_cost", cost_at(0), 32'hAAAA);
        check_eq("t7_after_latency", (q_lat.size() > 0) ? 32'(q_lat[0]) : 32'hDEAD, 32'd18);
        check_eq("t7_after_done", 32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
